idelay_eye_scan: RTL and testbench

Initiator for an IDELAY set-controller channel. The block sweeps `delay_target` across the tap range in fixed steps and waits for `delay_ready` at each tap. It then counts per-cycle error flags from the downstream word comparator and selects the centre of the widest error-free run. It sits between the link-training sequencer (which drives `start` and reads the results) and one IDELAY set-controller lane.

---
 rtl/idelay_eye_scan.sv | 197 +++++++++++++++++++
 tb/tb_idelay_eye_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/idelay_eye_scan.sv
// IDELAY eye scanner: steps an IDELAY lane across its tap range, counts comparator
// errors at each tap and parks the lane at the centre of the widest good run.
module idelay_eye_scan #(
  parameter int STEP          = 8,
  parameter int MAX_TAP       = 511,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_LOG2   = 10,
  parameter int ERR_THRESH    = 0,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clk160,
  input  logic        rstb,
  input  logic        start,
  input  logic        err_flag,
  input  logic        delay_ready,
  output logic [8:0]  delay_target,
  output logic        busy,
  output logic        done,
  output logic        scan_fail,
  output logic [8:0]  eye_center,
  output logic [6:0]  eye_width,
  output logic        tap_strobe,
  output logic [8:0]  tap_index,
  output logic [15:0] tap_err_count
);

  localparam int WIN_CYCLES = 1 << WINDOW_LOG2;
  localparam int TMR_MAX_A  = (TIMEOUT > WIN_CYCLES) ? TIMEOUT : WIN_CYCLES;
  localparam int TMR_MAX    = (TMR_MAX_A > SETTLE_CYCLES) ? TMR_MAX_A : SETTLE_CYCLES;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST     = TMR_W'(WIN_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    SET,
    WAIT_READY,
    SETTLE,
    COUNT,
    EVAL,
    FINAL_SET,
    FINAL_WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [TMR_W-1:0] tmr;
  logic [15:0]      err_cnt;
  logic [15:0]      cnt_inc;
  logic [8:0]       tap;
  logic [8:0]       restore_tap;
  logic [8:0]       cur_start;
  logic [8:0]       best_start;
  logic [9:0]       cur_len;
  logic [9:0]       best_len;

  logic [9:0]       next_tap;
  logic             last_tap;
  logic             tap_good;
  logic [9:0]       run_len_new;
  logic [8:0]       run_start_new;
  logic [9:0]       close_len;
  logic [8:0]       close_start;
  logic             do_close;
  logic             wait_expired;
  logic [15:0]      center_off;
  logic [8:0]       center_calc;

  // Run bookkeeping for the tap being evaluated. A bad tap closes the previous
  // run; the last tap also closes whatever run is still open, including itself.
  always_comb begin
    cnt_inc       = (err_flag && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    next_tap      = {1'b0, tap} + 10'(STEP);
    last_tap      = next_tap > 10'(MAX_TAP);
    tap_good      = err_cnt <= 16'(ERR_THRESH);
    run_len_new   = tap_good ? cur_len + 10'd1 : 10'd0;
    run_start_new = (tap_good && (cur_len == 10'd0)) ? tap : cur_start;
    close_len     = tap_good ? run_len_new : cur_len;
    close_start   = tap_good ? run_start_new : cur_start;
    do_close      = !tap_good || last_tap;
    wait_expired  = !delay_ready && (tmr == TIMEOUT_LAST);
    center_off    = ((16'(best_len) - 16'd1) * 16'(STEP)) >> 1;
    center_calc   = 9'(16'(best_start) + center_off);
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    tap_strobe = (state == EVAL);
    case (state)
      IDLE:       if (start) state_nxt = SET;
      SET:        state_nxt = WAIT_READY;
      WAIT_READY: begin
        if (delay_ready)       state_nxt = SETTLE;
        else if (wait_expired) state_nxt = DONE;
      end
      SETTLE:     if (tmr == SETTLE_LAST) state_nxt = COUNT;
      COUNT:      if (tmr == WIN_LAST) state_nxt = EVAL;
      EVAL:       state_nxt = last_tap ? FINAL_SET : SET;
      FINAL_SET:  state_nxt = FINAL_WAIT;
      FINAL_WAIT: if (delay_ready || wait_expired) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // One shared timer covers the ready timeout, the settle gap and the count window.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      tmr           <= '0;
      err_cnt       <= 16'd0;
      tap           <= 9'd0;
      restore_tap   <= 9'd0;
      cur_start     <= 9'd0;
      cur_len       <= 10'd0;
      best_start    <= 9'd0;
      best_len      <= 10'd0;
      delay_target  <= 9'd0;
      scan_fail     <= 1'b0;
      eye_center    <= 9'd0;
      eye_width     <= 7'd0;
      tap_index     <= 9'd0;
      tap_err_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            restore_tap  <= delay_target;
            tap          <= 9'd0;
            delay_target <= 9'd0;
            cur_start    <= 9'd0;
            cur_len      <= 10'd0;
            best_start   <= 9'd0;
            best_len     <= 10'd0;
            scan_fail    <= 1'b0;
          end
        end
        SET: tmr <= '0;
        WAIT_READY, FINAL_WAIT: begin
          if (delay_ready)       tmr <= '0;
          else if (wait_expired) scan_fail <= 1'b1;
          else                   tmr <= tmr + TMR_W'(1);
        end
        SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            tmr     <= '0;
            err_cnt <= 16'd0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        COUNT: begin
          err_cnt <= cnt_inc;
          tmr     <= tmr + TMR_W'(1);
          if (tmr == WIN_LAST) begin
            tap_index     <= tap;
            tap_err_count <= cnt_inc;
          end
        end
        EVAL: begin
          cur_len   <= run_len_new;
          cur_start <= run_start_new;
          if (do_close && (close_len > best_len)) begin
            best_len   <= close_len;
            best_start <= close_start;
          end
          if (!last_tap) begin
            tap          <= next_tap[8:0];
            delay_target <= next_tap[8:0];
          end
        end
        FINAL_SET: begin
          tmr <= '0;
          if (best_len != 10'd0) begin
            eye_center   <= center_calc;
            eye_width    <= (best_len > 10'd127) ? 7'd127 : best_len[6:0];
            delay_target <= center_calc;
          end else begin
            scan_fail    <= 1'b1;
            delay_target <= restore_tap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_eye_scan.sv
// Directed bench for idelay_eye_scan: models the set-controller ready handshake and
// a tap-dependent error pattern, then checks scan results against hand-derived values.
module tb_idelay_eye_scan;

  localparam int STEP     = 8;
  localparam int MAX_TAP  = 511;
  localparam int SETTLE   = 2;
  localparam int WIN_LOG2 = 4;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int TIMEOUT  = 64;
  localparam int LIMIT    = 5000;

  logic        clk160 = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        err_flag = 1'b0;
  logic        delay_ready = 1'b0;
  logic [8:0]  delay_target;
  logic        busy;
  logic        done;
  logic        scan_fail;
  logic [8:0]  eye_center;
  logic [6:0]  eye_width;
  logic        tap_strobe;
  logic [8:0]  tap_index;
  logic [15:0] tap_err_count;

  int checks = 0;
  int errors = 0;
  int err_mode = 0;
  bit stall_at_40 = 1'b0;
  logic [8:0] seen_target = 9'd0;
  int since_chg = 10;

  idelay_eye_scan #(
    .STEP(STEP), .MAX_TAP(MAX_TAP), .SETTLE_CYCLES(SETTLE),
    .WINDOW_LOG2(WIN_LOG2), .ERR_THRESH(0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk160(clk160), .rstb(rstb), .start(start), .err_flag(err_flag),
    .delay_ready(delay_ready), .delay_target(delay_target), .busy(busy),
    .done(done), .scan_fail(scan_fail), .eye_center(eye_center),
    .eye_width(eye_width), .tap_strobe(tap_strobe), .tap_index(tap_index),
    .tap_err_count(tap_err_count)
  );

  always #5 clk160 = ~clk160;

  function automatic bit bad_tap(input int t, input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return (t < 96) || (t > 248);
      2:       return !(((t >= 16) && (t <= 48)) || ((t >= 200) && (t <= 232)));
      default: return 1'b1;
    endcase
  endfunction

  // Set-controller and comparator model, updated away from the active edge.
  always @(negedge clk160) begin
    if (delay_target != seen_target) begin
      seen_target = delay_target;
      since_chg = 0;
    end else if (since_chg < 100) begin
      since_chg++;
    end
    delay_ready = (since_chg >= 3) && !(stall_at_40 && (delay_target == 9'd40));
    err_flag = bad_tap(int'(delay_target), err_mode);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input bit stall,
                               output int strobes, output int tap_errs,
                               output int strobe_cyc, output int done_cyc);
    int cyc;
    bit got_done;
    err_mode = mode;
    stall_at_40 = stall;
    strobes = 0;
    tap_errs = 0;
    strobe_cyc = -1;
    done_cyc = -1;
    got_done = 1'b0;
    cyc = 0;
    @(negedge clk160);
    start = 1'b1;
    @(negedge clk160);
    start = 1'b0;
    checkOutput("start busy", 32'(busy), 32'd1);
    checkOutput("start target", 32'(delay_target), 32'd0);
    while (!got_done && (cyc < LIMIT)) begin
      if (tap_strobe) begin
        if ((tap_index !== 9'(strobes * STEP)) ||
            (tap_err_count !== (bad_tap(strobes * STEP, mode) ? 16'(WIN) : 16'd0)))
          tap_errs++;
        strobes++;
        strobe_cyc = cyc;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        @(negedge clk160);
        cyc++;
      end
    end
    checkOutput("scan done", 32'(got_done), 32'd1);
    if (got_done) begin
      checkOutput("busy in done", 32'(busy), 32'd1);
      @(negedge clk160);
      checkOutput("done pulse", 32'(done), 32'd0);
      checkOutput("busy fall", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int strobes, tap_errs, strobe_cyc, done_cyc;
    bit found;

    repeat (3) @(negedge clk160);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset target", 32'(delay_target), 32'd0);
    checkOutput("reset center", 32'(eye_center), 32'd0);
    checkOutput("reset width", 32'(eye_width), 32'd0);
    checkOutput("reset fail", 32'(scan_fail), 32'd0);
    checkOutput("reset strobe", 32'(tap_strobe), 32'd0);
    rstb = 1'b1;
    repeat (2) @(negedge clk160);

    $display("[TB] clean eye");
    applyStimulus(0, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("clean strobes", 32'(strobes), 32'd64);
    checkOutput("clean tap data", 32'(tap_errs), 32'd0);
    checkOutput("clean width", 32'(eye_width), 32'd64);
    checkOutput("clean center", 32'(eye_center), 32'd252);
    checkOutput("clean target", 32'(delay_target), 32'd252);
    checkOutput("clean fail", 32'(scan_fail), 32'd0);

    $display("[TB] window 96..248");
    applyStimulus(1, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("win strobes", 32'(strobes), 32'd64);
    checkOutput("win tap data", 32'(tap_errs), 32'd0);
    checkOutput("win width", 32'(eye_width), 32'd20);
    checkOutput("win center", 32'(eye_center), 32'd172);
    checkOutput("win target", 32'(delay_target), 32'd172);
    checkOutput("win fail", 32'(scan_fail), 32'd0);

    $display("[TB] two equal runs");
    applyStimulus(2, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("tie tap data", 32'(tap_errs), 32'd0);
    checkOutput("tie width", 32'(eye_width), 32'd5);
    checkOutput("tie center", 32'(eye_center), 32'd32);
    checkOutput("tie target", 32'(delay_target), 32'd32);

    $display("[TB] closed eye restores previous tap");
    applyStimulus(0, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("pre center", 32'(eye_center), 32'd252);
    applyStimulus(3, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("closed strobes", 32'(strobes), 32'd64);
    checkOutput("closed tap data", 32'(tap_errs), 32'd0);
    checkOutput("closed fail", 32'(scan_fail), 32'd1);
    checkOutput("closed target", 32'(delay_target), 32'd252);
    checkOutput("closed center", 32'(eye_center), 32'd252);
    checkOutput("closed width", 32'(eye_width), 32'd64);

    $display("[TB] ready timeout at tap 40");
    applyStimulus(0, 1'b1, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("tmo strobes", 32'(strobes), 32'd5);
    checkOutput("tmo latency", 32'(done_cyc - strobe_cyc), 32'(TIMEOUT + 2));
    checkOutput("tmo fail", 32'(scan_fail), 32'd1);
    checkOutput("tmo target", 32'(delay_target), 32'd40);
    checkOutput("tmo center", 32'(eye_center), 32'd252);
    stall_at_40 = 1'b0;

    $display("[TB] reset during count at tap 80");
    err_mode = 0;
    @(negedge clk160);
    start = 1'b1;
    @(negedge clk160);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; (i < LIMIT) && !found; i++) begin
      @(negedge clk160);
      if (tap_strobe && (tap_index == 9'd72)) found = 1'b1;
    end
    checkOutput("reach tap 72", 32'(found), 32'd1);
    repeat (10) @(negedge clk160);
    checkOutput("pre-reset target", 32'(delay_target), 32'd80);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    rstb = 1'b0;
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst target", 32'(delay_target), 32'd0);
    checkOutput("rst center", 32'(eye_center), 32'd0);
    checkOutput("rst width", 32'(eye_width), 32'd0);
    checkOutput("rst fail", 32'(scan_fail), 32'd0);
    checkOutput("rst tap index", 32'(tap_index), 32'd0);
    checkOutput("rst tap count", 32'(tap_err_count), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    @(negedge clk160);
    rstb = 1'b1;
    applyStimulus(0, 1'b0, strobes, tap_errs, strobe_cyc, done_cyc);
    checkOutput("restart strobes", 32'(strobes), 32'd64);
    checkOutput("restart tap data", 32'(tap_errs), 32'd0);
    checkOutput("restart center", 32'(eye_center), 32'd252);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
